// File: rtl/mseq_gen.sv
// mseq_gen: parametrised maximal-length sequence generator.
//   Fibonacci LFSR with programmable taps. A clock-enable divider sets the
//   step rate. Seeds can be loaded at run time, and an all-zero state is
//   replaced by SEED. The block also produces a period sync pulse and
//   assembles the serial bits into parallel words.
// Ports:
//   CLK_50MHZ  in   system clock, rising edge
//   RST_N      in   asynchronous active-low reset
//   en         in   run enable; low freezes divider, LFSR and counters
//   load       in   one-cycle seed load strobe
//   seed_in    in   seed captured on load (zero is replaced by SEED)
//   out_fun    out  serial sequence bit, state MSB
//   data       out  last DATA_W emitted bits, oldest at MSB
//   data_valid out  one-cycle pulse when data holds a fresh word
//   sync       out  one-cycle pulse when the LFSR is back at its period start
//   lockup     out  sticky: a zero seed or zero state was replaced by SEED
module mseq_gen #(
  parameter int unsigned       LFSR_W = 5,
  parameter logic [LFSR_W-1:0] TAPS   = 5'b10100,
  parameter logic [LFSR_W-1:0] SEED   = 5'b00001,
  parameter int unsigned       DIV    = 1,
  parameter int unsigned       DATA_W = 8
) (
  input  logic              CLK_50MHZ,
  input  logic              RST_N,
  input  logic              en,
  input  logic              load,
  input  logic [LFSR_W-1:0] seed_in,
  output logic              out_fun,
  output logic [DATA_W-1:0] data,
  output logic              data_valid,
  output logic              sync,
  output logic              lockup
);

  localparam int unsigned DIV_CW = 16;
  localparam int unsigned BIT_CW = $clog2(DATA_W + 1);

  localparam logic [DIV_CW-1:0] DIV_LAST = DIV_CW'(DIV - 1);
  localparam logic [BIT_CW-1:0] BIT_LAST = BIT_CW'(DATA_W - 1);
  // Last step index of a period, 2^LFSR_W-2, built without overflowing at 32 bits.
  localparam logic [LFSR_W-1:0] PER_LAST = {{(LFSR_W - 1){1'b1}}, 1'b0};

  logic [LFSR_W-1:0] state, state_nxt;
  logic [DIV_CW-1:0] div_cnt, div_nxt;
  logic [LFSR_W-1:0] per_cnt, per_nxt;
  logic [BIT_CW-1:0] bit_cnt, bit_nxt;
  logic [DATA_W-1:0] data_nxt;
  logic              dv_nxt;
  logic              sync_nxt;
  logic              lockup_nxt;
  logic              tick_c;
  logic              fb_c;

  // Divider tick and Fibonacci feedback.
  assign tick_c  = en && (div_cnt == DIV_LAST);
  assign fb_c    = ^(state & TAPS);
  assign out_fun = state[LFSR_W-1];

  // Next-state logic: load beats lockup recovery, which beats a normal step.
  always_comb begin
    state_nxt  = state;
    div_nxt    = div_cnt;
    per_nxt    = per_cnt;
    bit_nxt    = bit_cnt;
    data_nxt   = data;
    dv_nxt     = 1'b0;
    sync_nxt   = 1'b0;
    lockup_nxt = lockup;

    if (load) begin
      div_nxt = '0;
      per_nxt = '0;
      bit_nxt = '0;
      if (seed_in == '0) begin
        state_nxt  = SEED;
        lockup_nxt = 1'b1;
      end else begin
        state_nxt  = seed_in;
        lockup_nxt = 1'b0;
      end
    end else if (state == '0) begin
      // An all-zero state cannot be reached normally; recover to SEED.
      state_nxt  = SEED;
      lockup_nxt = 1'b1;
    end else if (en) begin
      if (tick_c) begin
        div_nxt   = '0;
        state_nxt = {state[LFSR_W-2:0], fb_c};
        // The emitted bit is the pre-step serial output.
        data_nxt  = {data[DATA_W-2:0], state[LFSR_W-1]};

        if (bit_cnt == BIT_LAST) begin
          bit_nxt = '0;
          dv_nxt  = 1'b1;
        end else begin
          bit_nxt = bit_cnt + BIT_CW'(1);
        end

        if (per_cnt == PER_LAST) begin
          per_nxt  = '0;
          sync_nxt = 1'b1;
        end else begin
          per_nxt = per_cnt + LFSR_W'(1);
        end
      end else begin
        div_nxt = div_cnt + DIV_CW'(1);
      end
    end
  end

  // State registers.
  always_ff @(posedge CLK_50MHZ or negedge RST_N) begin
    if (!RST_N) begin
      state      <= SEED;
      div_cnt    <= '0;
      per_cnt    <= '0;
      bit_cnt    <= '0;
      data       <= '0;
      data_valid <= 1'b0;
      sync       <= 1'b0;
      lockup     <= 1'b0;
    end else begin
      state      <= state_nxt;
      div_cnt    <= div_nxt;
      per_cnt    <= per_nxt;
      bit_cnt    <= bit_nxt;
      data       <= data_nxt;
      data_valid <= dv_nxt;
      sync       <= sync_nxt;
      lockup     <= lockup_nxt;
    end
  end

endmodule

// File: tb/tb_mseq_gen.sv
// tb_mseq_gen: directed self-checking bench for mseq_gen.
//   dut0 uses default parameters; dut1 uses DIV=4 with a toggling enable.
module tb_mseq_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en0, load0, en1, load1;
  logic [4:0] seed0, seed1;
  logic       out0, dv0, sync0, lock0;
  logic       out1, dv1, sync1, lock1;
  logic [7:0] data0, data1;

  int compared   = 0;
  int mismatched = 0;

  // out_fun after 0..9 steps from SEED=00001, first value at MSB.
  logic [9:0] exp_bits = 10'b0000100101;

  always #5 clk = ~clk;

  mseq_gen dut0 (
    .CLK_50MHZ (clk),
    .RST_N     (rst_n),
    .en        (en0),
    .load      (load0),
    .seed_in   (seed0),
    .out_fun   (out0),
    .data      (data0),
    .data_valid(dv0),
    .sync      (sync0),
    .lockup    (lock0)
  );

  mseq_gen #(.DIV(4)) dut1 (
    .CLK_50MHZ (clk),
    .RST_N     (rst_n),
    .en        (en1),
    .load      (load1),
    .seed_in   (seed1),
    .out_fun   (out1),
    .data      (data1),
    .data_valid(dv1),
    .sync      (sync1),
    .lockup    (lock1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick_clk;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    en0 = 1'b0; load0 = 1'b0; seed0 = '0;
    en1 = 1'b0; load1 = 1'b0; seed1 = '0;
    #12;
    chk("rst_out",    out0,  1'b0);
    chk("rst_data",   data0, 8'h00);
    chk("rst_dv",     dv0,   1'b0);
    chk("rst_sync",   sync0, 1'b0);
    chk("rst_lockup", lock0, 1'b0);
    chk("rst_out1",   out1,  1'b0);

    // Free run with DIV=1: sequence, word pulses, period sync.
    rst_n = 1'b1;
    en0   = 1'b1;
    chk("seq_0", out0, exp_bits[9]);
    for (int k = 1; k <= 62; k++) begin
      tick_clk();
      if (k <= 9) chk("seq", out0, exp_bits[9-k]);
      if (k >= 31 && k <= 40) chk("period_repeat", out0, exp_bits[40-k]);
      chk("run_dv",   dv0,   (k % 8) == 0);
      chk("run_sync", sync0, (k == 31) || (k == 62));
      if (k == 8)  chk("data_w1", data0, 8'h09);
      if (k == 16) chk("data_w2", data0, 8'h67);
      if (k == 24) chk("data_w3", data0, 8'hC6);
      if (k == 62) chk("data_62", data0, 8'h75);
    end

    // Zero seed load in a tick cycle: SEED used, lockup set, no step.
    load0 = 1'b1; seed0 = 5'b00000;
    tick_clk();
    load0 = 1'b0;
    chk("ld0_lockup", lock0, 1'b1);
    chk("ld0_out",    out0,  1'b0);
    chk("ld0_data",   data0, 8'h75);
    chk("ld0_dv",     dv0,   1'b0);
    chk("ld0_sync",   sync0, 1'b0);

    // Non-zero seed clears lockup and restarts the word counter.
    load0 = 1'b1; seed0 = 5'b10000;
    tick_clk();
    load0 = 1'b0;
    chk("ld1_lockup", lock0, 1'b0);
    chk("ld1_out",    out0,  1'b1);
    chk("ld1_data",   data0, 8'h75);
    for (int j = 1; j <= 8; j++) begin
      tick_clk();
      if (j == 1) chk("ld1_step_out", out0, 1'b0);
      chk("ld1_dv", dv0, j == 8);
      if (j == 8) chk("ld1_data_w", data0, 8'h84);
    end

    // Set lockup, run mid-word, then reset asynchronously.
    load0 = 1'b1; seed0 = 5'b00000;
    tick_clk();
    load0 = 1'b0;
    chk("ld2_lockup", lock0, 1'b1);
    for (int j = 0; j < 3; j++) tick_clk();
    rst_n = 1'b0;
    #2;
    chk("mid_rst_data",   data0, 8'h00);
    chk("mid_rst_out",    out0,  1'b0);
    chk("mid_rst_lockup", lock0, 1'b0);
    chk("mid_rst_dv",     dv0,   1'b0);
    chk("mid_rst_sync",   sync0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      tick_clk();
      chk("post_rst_dv", dv0, j == 8);
      if (j == 8) chk("post_rst_data", data0, 8'h09);
    end

    // DIV=4 with en toggling every cycle: one step per 8 clocks.
    en0 = 1'b0;
    for (int e = 1; e <= 64; e++) begin
      en1 = (e % 2) == 1;
      tick_clk();
      if (((e + 1) / 8) <= 4) chk("div_out", out1, exp_bits[9-((e+1)/8)]);
      chk("div_dv", dv1, e == 63);
      if (e == 64) chk("div_data", data1, 8'h09);
    end
    en1 = 1'b0;

    // dut0 stayed frozen with en low.
    chk("frozen_out",  out0,  1'b0);
    chk("frozen_data", data0, 8'h09);
    chk("frozen_dv",   dv0,   1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
